// File: rtl/l2_cache_arb_if.sv
// Signal bundle around the L2 front-end arbiter: core request ports, SMI fill
// restart path, and the registered packet handed to the directory stage.
interface l2_cache_arb_if #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 26
);
    localparam int CW = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]            core_req_valid;
    logic [NUM_CORES*3-1:0]          core_req_op;
    logic [NUM_CORES*2-1:0]          core_req_strand;
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_address;
    logic [NUM_CORES*512-1:0]        core_req_data;
    logic [NUM_CORES*64-1:0]         core_req_mask;
    logic [NUM_CORES-1:0]            core_req_ack;

    logic                  restart_valid;
    logic [2:0]            restart_op;
    logic [CW-1:0]         restart_core;
    logic [1:0]            restart_strand;
    logic [ADDR_WIDTH-1:0] restart_address;
    logic [511:0]          restart_data;
    logic [63:0]           restart_mask;
    logic [511:0]          restart_data_from_memory;
    logic                  restart_ack;

    logic smi_stall;

    logic                  arb_valid;
    logic [2:0]            arb_op;
    logic [CW-1:0]         arb_core;
    logic [1:0]            arb_strand;
    logic [ADDR_WIDTH-1:0] arb_address;
    logic [511:0]          arb_data;
    logic [63:0]           arb_mask;
    logic                  arb_is_l2_fill;
    logic [511:0]          arb_data_from_memory;

    modport slave (
        input  core_req_valid, core_req_op, core_req_strand, core_req_address,
               core_req_data, core_req_mask,
        output core_req_ack,
        input  restart_valid, restart_op, restart_core, restart_strand,
               restart_address, restart_data, restart_mask, restart_data_from_memory,
        output restart_ack,
        input  smi_stall,
        output arb_valid, arb_op, arb_core, arb_strand, arb_address, arb_data,
               arb_mask, arb_is_l2_fill, arb_data_from_memory
    );

    modport master (
        output core_req_valid, core_req_op, core_req_strand, core_req_address,
               core_req_data, core_req_mask,
        input  core_req_ack,
        output restart_valid, restart_op, restart_core, restart_strand,
               restart_address, restart_data, restart_mask, restart_data_from_memory,
        input  restart_ack,
        output smi_stall,
        input  arb_valid, arb_op, arb_core, arb_strand, arb_address, arb_data,
               arb_mask, arb_is_l2_fill, arb_data_from_memory
    );
endinterface

// File: rtl/l2_cache_arb.sv
// L2 front-end arbiter: picks one fill restart or one round-robin core request
// per cycle and registers it into the directory stage.
module l2_cache_arb #(
    parameter int NUM_CORES         = 4,
    parameter int MAX_RESTART_BURST = 4,
    parameter int ADDR_WIDTH        = 26
) (
    input logic           clk,
    input logic           reset_n,
    l2_cache_arb_if.slave bus
);
    localparam int CW = $clog2(NUM_CORES);
    localparam int BW = $clog2(MAX_RESTART_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_RESTART_BURST);

    logic [CW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;

    logic any_core_valid;
    logic core_eligible;
    logic grant_restart;
    logic grant_core;

    logic          rr_found;
    logic [CW-1:0] rr_idx;
    logic [CW-1:0] cand;

    logic [2:0]            sel_op;
    logic [1:0]            sel_strand;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [511:0]          sel_data;
    logic [63:0]           sel_mask;

    // Restarts bypass smi_stall since a fill drains SMI; the burst limit only
    // bites when a core could actually be served instead.
    assign any_core_valid = |bus.core_req_valid;
    assign core_eligible  = any_core_valid && !bus.smi_stall;
    assign grant_restart  = reset_n && bus.restart_valid &&
                            (!core_eligible || (burst_cnt < BURST_MAX));
    assign grant_core     = reset_n && !grant_restart && core_eligible;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = rr_ptr + CW'(k);
            if (!rr_found && bus.core_req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_op     = '0;
        sel_strand = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_mask   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (CW'(i) == rr_idx) begin
                sel_op     = bus.core_req_op[i*3 +: 3];
                sel_strand = bus.core_req_strand[i*2 +: 2];
                sel_addr   = bus.core_req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data   = bus.core_req_data[i*512 +: 512];
                sel_mask   = bus.core_req_mask[i*64 +: 64];
            end
        end
    end

    assign bus.core_req_ack = grant_core ? (NUM_CORES'(1) << rr_idx) : '0;
    assign bus.restart_ack  = grant_restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.arb_valid            <= 1'b0;
            bus.arb_op               <= '0;
            bus.arb_core             <= '0;
            bus.arb_strand           <= '0;
            bus.arb_address          <= '0;
            bus.arb_data             <= '0;
            bus.arb_mask             <= '0;
            bus.arb_is_l2_fill       <= 1'b0;
            bus.arb_data_from_memory <= '0;
            rr_ptr                   <= '0;
            burst_cnt                <= '0;
        end else begin
            bus.arb_valid      <= grant_restart || grant_core;
            bus.arb_is_l2_fill <= grant_restart;
            if (grant_restart) begin
                bus.arb_op               <= bus.restart_op;
                bus.arb_core             <= bus.restart_core;
                bus.arb_strand           <= bus.restart_strand;
                bus.arb_address          <= bus.restart_address;
                bus.arb_data             <= bus.restart_data;
                bus.arb_mask             <= bus.restart_mask;
                bus.arb_data_from_memory <= bus.restart_data_from_memory;
            end else if (grant_core) begin
                bus.arb_op      <= sel_op;
                bus.arb_core    <= rr_idx;
                bus.arb_strand  <= sel_strand;
                bus.arb_address <= sel_addr;
                bus.arb_data    <= sel_data;
                bus.arb_mask    <= sel_mask;
            end

            if (grant_core) begin
                rr_ptr <= rr_idx + CW'(1);
            end

            // Counts restarts that jumped ahead of waiting cores.
            if (!any_core_valid || grant_core) begin
                burst_cnt <= '0;
            end else if (grant_restart && (burst_cnt < BURST_MAX)) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end

    ack_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.core_req_ack));
    ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.restart_ack && (|bus.core_req_ack)));
endmodule

// File: tb/tb_l2_cache_arb.sv
// Randomised scoreboard bench for l2_cache_arb with a queue-based reference
// model of restart priority, burst fairness and round-robin core service.
module tb_l2_cache_arb;
    localparam int N    = 4;
    localparam int MAXB = 4;
    localparam int AW   = 26;
    localparam int CW   = $clog2(N);

    typedef struct {
        logic [2:0]    op;
        logic [1:0]    strand;
        logic [AW-1:0] addr;
        logic [511:0]  data;
        logic [63:0]   mask;
        logic [CW-1:0] core;
        logic          fill;
        logic [511:0]  mem;
    } pkt_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    l2_cache_arb_if #(.NUM_CORES(N), .ADDR_WIDTH(AW)) bus ();

    l2_cache_arb #(
        .NUM_CORES(N),
        .MAX_RESTART_BURST(MAXB),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_t exp_q[$];
    pkt_t core_pkt[N];
    bit   core_pend[N];
    bit   keep_core[N];
    pkt_t rst_pkt;
    bit   rst_pend;
    bit   keep_rst;
    bit   stall;
    bit   random_mode;

    int           m_ptr;
    int           m_burst;
    logic [511:0] m_mem;

    int   dut_grant;
    logic seen_valid;
    logic seen_fill;

    task automatic checkOutput(input string name, input logic [511:0] act,
                               input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic pkt_t randPkt(input int core, input bit fill);
        pkt_t p;
        p.op     = 3'($urandom);
        p.strand = 2'($urandom);
        p.addr   = AW'($urandom);
        for (int w = 0; w < 16; w++) p.data[w*32 +: 32] = $urandom;
        p.mask   = {$urandom, $urandom};
        p.core   = fill ? CW'($urandom) : CW'(core);
        p.fill   = fill;
        p.mem    = '0;
        if (fill) for (int w = 0; w < 16; w++) p.mem[w*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic driveBus();
        for (int i = 0; i < N; i++) begin
            bus.core_req_valid[i]              = core_pend[i];
            bus.core_req_op[i*3 +: 3]          = core_pkt[i].op;
            bus.core_req_strand[i*2 +: 2]      = core_pkt[i].strand;
            bus.core_req_address[i*AW +: AW]   = core_pkt[i].addr;
            bus.core_req_data[i*512 +: 512]    = core_pkt[i].data;
            bus.core_req_mask[i*64 +: 64]      = core_pkt[i].mask;
        end
        bus.restart_valid            = rst_pend;
        bus.restart_op               = rst_pkt.op;
        bus.restart_core             = rst_pkt.core;
        bus.restart_strand           = rst_pkt.strand;
        bus.restart_address          = rst_pkt.addr;
        bus.restart_data             = rst_pkt.data;
        bus.restart_mask             = rst_pkt.mask;
        bus.restart_data_from_memory = rst_pkt.mem;
        bus.smi_stall                = stall;
    endtask

    task automatic clearAll();
        for (int i = 0; i < N; i++) begin
            core_pend[i] = 1'b0;
            keep_core[i] = 1'b0;
        end
        rst_pend    = 1'b0;
        keep_rst    = 1'b0;
        stall       = 1'b0;
        random_mode = 1'b0;
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases at +2.
    task automatic resetDut();
        reset_n = 1'b0;
        exp_q.delete();
        m_ptr   = 0;
        m_burst = 0;
        m_mem   = '0;
        driveBus();
        #1;
        checkOutput("reset_core_ack", bus.core_req_ack, 0);
        checkOutput("reset_restart_ack", bus.restart_ack, 0);
        checkOutput("reset_arb_valid", bus.arb_valid, 0);
        checkOutput("reset_fill", bus.arb_is_l2_fill, 0);
        checkOutput("reset_addr", bus.arb_address, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // One arbitration cycle: starts and ends at 2 time units after a rising edge.
    task automatic applyStimulus();
        int          g;
        bit          any;
        logic [N-1:0] exp_ack;
        pkt_t        p;
        for (int i = 0; i < N; i++) begin
            if (!core_pend[i] && (keep_core[i] || (random_mode && $urandom_range(2) == 0))) begin
                core_pend[i] = 1'b1;
                core_pkt[i]  = randPkt(i, 1'b0);
            end
        end
        if (!rst_pend && (keep_rst || (random_mode && $urandom_range(3) == 0))) begin
            rst_pend = 1'b1;
            rst_pkt  = randPkt(0, 1'b1);
        end
        if (random_mode) stall = ($urandom_range(4) == 0);
        driveBus();
        #1;
        any = 1'b0;
        for (int i = 0; i < N; i++) any |= core_pend[i];
        g = -1;
        if (rst_pend && (!(any && !stall) || m_burst < MAXB)) begin
            g = N;
        end else if (any && !stall) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && core_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ack = '0;
        if (g >= 0 && g < N) exp_ack[g] = 1'b1;
        checkOutput("core_req_ack", bus.core_req_ack, exp_ack);
        checkOutput("restart_ack", bus.restart_ack, g == N);

        dut_grant = -1;
        if (bus.restart_ack) dut_grant = N;
        else for (int i = 0; i < N; i++) if (bus.core_req_ack[i]) dut_grant = i;

        if (g == N) begin
            p     = rst_pkt;
            m_mem = rst_pkt.mem;
            exp_q.push_back(p);
        end else if (g >= 0) begin
            p     = core_pkt[g];
            p.mem = m_mem;
            exp_q.push_back(p);
        end

        if (g >= 0 && g < N) m_ptr = (g + 1) % N;
        if (!any || (g >= 0 && g < N)) m_burst = 0;
        else if (g == N && m_burst < MAXB) m_burst++;

        if (bus.restart_ack) rst_pend = 1'b0;
        for (int i = 0; i < N; i++) if (bus.core_req_ack[i]) core_pend[i] = 1'b0;

        @(posedge clk);
        #1;
        seen_valid = bus.arb_valid;
        seen_fill  = bus.arb_is_l2_fill;
        #1;
    endtask

    initial begin : monitor
        pkt_t p;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && bus.arb_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_packet", bus.arb_valid, 0);
                end else begin
                    p = exp_q.pop_front();
                    checkOutput("arb_op", bus.arb_op, p.op);
                    checkOutput("arb_strand", bus.arb_strand, p.strand);
                    checkOutput("arb_address", bus.arb_address, p.addr);
                    checkOutput("arb_data", bus.arb_data, p.data);
                    checkOutput("arb_mask", bus.arb_mask, p.mask);
                    checkOutput("arb_core", bus.arb_core, p.core);
                    checkOutput("arb_is_l2_fill", bus.arb_is_l2_fill, p.fill);
                    checkOutput("arb_data_from_memory", bus.arb_data_from_memory, p.mem);
                end
            end
        end
    end

    initial begin
        clearAll();
        for (int i = 0; i < N; i++) core_pkt[i] = randPkt(i, 1'b0);
        rst_pkt = randPkt(0, 1'b1);
        #2;

        $display("[TB] reset with every requester valid");
        for (int i = 0; i < N; i++) core_pend[i] = 1'b1;
        rst_pend = 1'b1;
        resetDut();
        applyStimulus();
        checkOutput("first_grant_restart", dut_grant, N);

        $display("[TB] round-robin over all cores");
        clearAll();
        for (int i = 0; i < N; i++) keep_core[i] = 1'b1;
        resetDut();
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput("rr_order", dut_grant, c % N);
        end

        $display("[TB] restart burst limit against core 2");
        clearAll();
        resetDut();
        keep_core[2] = 1'b1;
        keep_rst     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            checkOutput("burst_order", dut_grant, (c == MAXB) ? 2 : N);
        end

        $display("[TB] smi_stall blocks cores only");
        clearAll();
        resetDut();
        keep_core[1] = 1'b1;
        keep_core[3] = 1'b1;
        stall        = 1'b1;
        repeat (2) begin
            applyStimulus();
            checkOutput("stall_no_grant", dut_grant, -1);
            checkOutput("stall_arb_valid", seen_valid, 0);
        end
        keep_rst = 1'b1;
        applyStimulus();
        checkOutput("stall_restart_grant", dut_grant, N);
        checkOutput("stall_restart_fill", seen_fill, 1);

        $display("[TB] pointer wrap from core 3 to core 0");
        clearAll();
        resetDut();
        core_pend[2] = 1'b1;
        core_pkt[2]  = randPkt(2, 1'b0);
        applyStimulus();
        checkOutput("wrap_setup", dut_grant, 2);
        core_pend[0] = 1'b1;
        core_pkt[0]  = randPkt(0, 1'b0);
        core_pend[3] = 1'b1;
        core_pkt[3]  = randPkt(3, 1'b0);
        applyStimulus();
        checkOutput("wrap_first", dut_grant, 3);
        applyStimulus();
        checkOutput("wrap_second", dut_grant, 0);

        $display("[TB] asynchronous reset in the middle of a restart burst");
        clearAll();
        resetDut();
        keep_core[1] = 1'b1;
        keep_rst     = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("pre_reset_valid", bus.arb_valid, 1);
        resetDut();
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            checkOutput("post_reset_burst", dut_grant, (c == MAXB) ? 1 : N);
        end

        $display("[TB] randomised traffic");
        clearAll();
        resetDut();
        random_mode = 1'b1;
        repeat (3000) applyStimulus();
        clearAll();
        driveBus();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
